// File: rtl/csr_lclint.sv
// Local interrupt pending/enable block for mip/mie IDs 16 and up, with arbiter and request FSM.
// Define LCLINT_EDGE_EN to add the LCLMODE CSR and per-source edge capture.
module csr_lclint #(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 16,
    parameter int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               CSRMWriteM,
    input  logic               CSRSWriteM,
    input  logic [11:0]        CSRAdrM,
    input  logic [XLEN-1:0]    CSRWriteValM,
    input  logic [NUM_IRQ-1:0] LclIrq,
    input  logic [NUM_IRQ-1:0] LclDeleg,
    input  logic               IntAckM,
    output logic [NUM_IRQ-1:0] LclIP,
    output logic [NUM_IRQ-1:0] LclIE,
    output logic               IntReq,
    output logic [IDW-1:0]     IntId,
    output logic               IntToS
);

    localparam int HI = 16 + NUM_IRQ - 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q;
    logic               req_q;
    logic [IDW-1:0]     id_q;
    logic               tos_q;
    logic [NUM_IRQ-1:0] ie_q, ie_d;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] id_hot;
    logic [NUM_IRQ-1:0] wdata;
    logic [IDW-1:0]     win_id;
    logic               win_tos;
    logic               cur_live;
    logic               mie_wr, sie_wr;
    logic               unused_wval;

    assign wdata  = CSRWriteValM[HI:16];
    assign mie_wr = CSRMWriteM && (CSRAdrM == 12'h304);
    assign sie_wr = CSRSWriteM && (CSRAdrM == 12'h104);

    generate
        if (HI < XLEN - 1) begin : g_unused_hi
            assign unused_wval = ^{CSRWriteValM[XLEN-1:HI+1], CSRWriteValM[15:0]};
        end else begin : g_unused_lo
            assign unused_wval = ^CSRWriteValM[15:0];
        end
    endgenerate

    // S-mode writes only reach the enables of delegated sources
    always_comb begin
        ie_d = ie_q;
        if (mie_wr) begin
            ie_d = wdata;
        end else if (sie_wr) begin
            ie_d = (ie_q & ~LclDeleg) | (wdata & LclDeleg);
        end
    end

    always_comb begin
        id_hot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            id_hot[i] = (id_q == IDW'(i));
        end
    end

`ifdef LCLINT_EDGE_EN
    logic               mip_wr, sip_wr, mode_wr, ack_go;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] epend_q, epend_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] rise, wset, wclr, aclr;

    assign mip_wr  = CSRMWriteM && (CSRAdrM == 12'h344);
    assign sip_wr  = CSRSWriteM && (CSRAdrM == 12'h144);
    assign mode_wr = CSRMWriteM && (CSRAdrM == 12'h7C0);
    assign ack_go  = IntAckM && (state_q == REQ);

    // An edge seen this cycle wins over any write-0 or ack clear
    always_comb begin
        hist_d = LclIrq;
        mode_d = mode_wr ? wdata : mode_q;
        rise   = LclIrq & ~hist_q;
        wset   = '0;
        wclr   = '0;
        if (mip_wr) begin
            wset = wdata;
            wclr = ~wdata;
        end else if (sip_wr) begin
            wset = wdata & LclDeleg;
            wclr = ~wdata & LclDeleg;
        end
        aclr    = ack_go ? id_hot : '0;
        epend_d = mode_q & (rise | wset | (epend_q & ~(wclr | aclr)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= '0;
            epend_q <= '0;
            hist_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            epend_q <= epend_d;
            hist_q  <= hist_d;
        end
    end

    assign ip = (mode_q & epend_q) | (~mode_q & LclIrq);
`else
    assign ip = LclIrq;
`endif

    assign cand     = ip & ie_q;
    assign cur_live = |(cand & id_hot);

    always_comb begin
        win_id  = '0;
        win_tos = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id  = IDW'(i);
                win_tos = LclDeleg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q <= '0;
        end else begin
            ie_q <= ie_d;
        end
    end

    // Winner is frozen while requesting; no pre-emption
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            tos_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        id_q    <= win_id;
                        tos_q   <= win_tos;
                    end
                end
                REQ: begin
                    if (IntAckM || !cur_live) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign LclIP  = ip;
    assign LclIE  = ie_q;
    assign IntReq = req_q;
    assign IntId  = id_q;
    assign IntToS = tos_q;

endmodule

// File: tb/tb_csr_lclint.sv
// Directed vector bench for csr_lclint (16-source and 5-source instances).
// Edge-mode sequences are compiled in when LCLINT_EDGE_EN is defined.
module tb_csr_lclint;

    typedef struct {
        logic        mw;
        logic        sw;
        logic [11:0] adr;
        logic [15:0] wv;
        logic [15:0] irq;
        logic [15:0] dlg;
        logic        ack;
        logic [15:0] ip;
        logic [15:0] ie;
        logic        req;
        logic [3:0]  id;
        logic        tos;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        mw, sw, ack;
    logic [11:0] adr;
    logic [63:0] wval;
    logic [15:0] irq, dlg;
    logic [15:0] ip, ie;
    logic        req, tos;
    logic [3:0]  id;

    logic        mw5, sw5, ack5;
    logic [11:0] adr5;
    logic [63:0] wval5;
    logic [4:0]  irq5, dlg5;
    logic [4:0]  ip5, ie5;
    logic        req5, tos5;
    logic [2:0]  id5;

    int n_vec = 0;
    int n_err = 0;

    vec_t tv[31];

    csr_lclint #(.XLEN(64), .NUM_IRQ(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .CSRMWriteM(mw), .CSRSWriteM(sw),
        .CSRAdrM(adr), .CSRWriteValM(wval),
        .LclIrq(irq), .LclDeleg(dlg), .IntAckM(ack),
        .LclIP(ip), .LclIE(ie), .IntReq(req),
        .IntId(id), .IntToS(tos)
    );

    csr_lclint #(.XLEN(64), .NUM_IRQ(5)) dut5 (
        .clk(clk), .reset_n(reset_n),
        .CSRMWriteM(mw5), .CSRSWriteM(sw5),
        .CSRAdrM(adr5), .CSRWriteValM(wval5),
        .LclIrq(irq5), .LclDeleg(dlg5), .IntAckM(ack5),
        .LclIP(ip5), .LclIE(ie5), .IntReq(req5),
        .IntId(id5), .IntToS(tos5)
    );

    function automatic vec_t mk(
        input logic mw_i, input logic sw_i, input logic [11:0] adr_i,
        input logic [15:0] wv_i, input logic [15:0] irq_i,
        input logic [15:0] dlg_i, input logic ack_i,
        input logic [15:0] ip_i, input logic [15:0] ie_i,
        input logic req_i, input logic [3:0] id_i, input logic tos_i);
        vec_t v;
        v.mw = mw_i; v.sw = sw_i; v.adr = adr_i; v.wv = wv_i;
        v.irq = irq_i; v.dlg = dlg_i; v.ack = ack_i;
        v.ip = ip_i; v.ie = ie_i; v.req = req_i; v.id = id_i; v.tos = tos_i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        mw   = v.mw;
        sw   = v.sw;
        adr  = v.adr;
        wval = {32'hDEAD_BEEF, v.wv, 16'hFFFF};
        irq  = v.irq;
        dlg  = v.dlg;
        ack  = v.ack;
        step();
        chk({tag, ".ip"}, ip, v.ip);
        chk({tag, ".ie"}, ie, v.ie);
        chk({tag, ".req"}, {15'd0, req}, {15'd0, v.req});
        chk({tag, ".id"}, {12'd0, id}, {12'd0, v.id});
        chk({tag, ".tos"}, {15'd0, tos}, {15'd0, v.tos});
    endtask

    initial begin
        mw = 0; sw = 0; adr = '0; wval = '0; irq = '0; dlg = '0; ack = 0;
        mw5 = 0; sw5 = 0; adr5 = '0; wval5 = '0; irq5 = '0; dlg5 = '0; ack5 = 0;

        // mw sw adr wv irq dlg ack | ip ie req id tos
        tv[0]  = mk(1, 0, 12'h304, 16'h0008, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0008, 0, 0, 0);
        tv[1]  = mk(0, 0, 12'h000, 16'h0000, 16'h0008, 16'h0000, 0, 16'h0008, 16'h0008, 1, 3, 0);
        tv[2]  = mk(0, 0, 12'h000, 16'h0000, 16'h0008, 16'h0000, 0, 16'h0008, 16'h0008, 1, 3, 0);
        tv[3]  = mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0008, 0, 3, 0);
        tv[4]  = mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0008, 0, 3, 0);
        tv[5]  = mk(1, 0, 12'h304, 16'h0024, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0024, 0, 3, 0);
        tv[6]  = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 0, 16'h0024, 16'h0024, 1, 2, 0);
        tv[7]  = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 1, 16'h0024, 16'h0024, 0, 2, 0);
        tv[8]  = mk(0, 0, 12'h000, 16'h0000, 16'h0020, 16'h0000, 0, 16'h0020, 16'h0024, 1, 5, 0);
        tv[9]  = mk(0, 0, 12'h000, 16'h0000, 16'h0020, 16'h0000, 1, 16'h0020, 16'h0024, 0, 5, 0);
        tv[10] = mk(0, 0, 12'h000, 16'h0000, 16'h0020, 16'h0000, 0, 16'h0020, 16'h0024, 1, 5, 0);
        tv[11] = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 0, 16'h0024, 16'h0024, 1, 5, 0);
        tv[12] = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 1, 16'h0024, 16'h0024, 0, 5, 0);
        tv[13] = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 0, 16'h0024, 16'h0024, 1, 2, 0);
        tv[14] = mk(1, 0, 12'h304, 16'h0000, 16'h0024, 16'h0000, 0, 16'h0024, 16'h0000, 1, 2, 0);
        tv[15] = mk(0, 0, 12'h000, 16'h0000, 16'h0024, 16'h0000, 0, 16'h0024, 16'h0000, 0, 2, 0);
        tv[16] = mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 2, 0);
        tv[17] = mk(0, 1, 12'h104, 16'hFFFF, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0001, 0, 2, 0);
        tv[18] = mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0001, 16'h0001, 1, 0, 1);
        tv[19] = mk(1, 0, 12'h304, 16'h0002, 16'h0001, 16'h0001, 0, 16'h0001, 16'h0002, 1, 0, 1);
        tv[20] = mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0001, 16'h0002, 0, 0, 1);
        tv[21] = mk(0, 1, 12'h104, 16'h0000, 16'h0002, 16'h0003, 0, 16'h0002, 16'h0000, 1, 1, 1);
        tv[22] = mk(0, 0, 12'h000, 16'h0000, 16'h0002, 16'h0003, 0, 16'h0002, 16'h0000, 0, 1, 1);
        tv[23] = mk(0, 1, 12'h104, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1);
        tv[24] = mk(1, 0, 12'h344, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1);
        tv[25] = mk(1, 0, 12'h305, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1);
        tv[26] = mk(1, 0, 12'h304, 16'h8000, 16'h8000, 16'h0000, 0, 16'h8000, 16'h8000, 0, 1, 1);
        tv[27] = mk(0, 0, 12'h000, 16'h0000, 16'h8000, 16'h0000, 0, 16'h8000, 16'h8000, 1, 15, 0);
        tv[28] = mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h8000, 0, 15, 0);
        tv[29] = mk(0, 1, 12'h104, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0000, 16'h8001, 0, 15, 0);
        tv[30] = mk(0, 1, 12'h104, 16'h0000, 16'h0000, 16'h8000, 0, 16'h0000, 16'h0001, 0, 15, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", {15'd0, req}, 16'd0);
        chk("rst.id", {12'd0, id}, 16'd0);
        chk("rst.tos", {15'd0, tos}, 16'd0);
        chk("rst.ie", ie, 16'd0);
        chk("rst.ip", ip, 16'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            apply(tv[i], $sformatf("v%0d", i));
        end

        // 5-source instance: CSR bits above 4 tied off, ids stay in range
        mw5 = 1; adr5 = 12'h304; wval5 = {32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF};
        step();
        mw5 = 0; adr5 = '0;
        chk("n5.ie", {11'd0, ie5}, 16'h001F);
        irq5 = 5'h10;
        step();
        chk("n5.req", {15'd0, req5}, 16'd1);
        chk("n5.id4", {13'd0, id5}, 16'd4);
        irq5 = 5'h1F;
        step();
        chk("n5.nopre", {13'd0, id5}, 16'd4);
        ack5 = 1;
        step();
        ack5 = 0;
        chk("n5.ackreq", {15'd0, req5}, 16'd0);
        step();
        chk("n5.rereq", {15'd0, req5}, 16'd1);
        chk("n5.id0", {13'd0, id5}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            irq5 = 5'($urandom);
            ack5 = 1'($urandom);
            step();
            chk($sformatf("n5.idmax%0d", k), {15'd0, (id5 <= 3'd4)}, 16'd1);
        end
        ack5 = 0;

        // Reset asserted while a request is outstanding
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0001, 16'h0001, 1, 0, 0), "r1");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid.req", {15'd0, req}, 16'd0);
        chk("rmid.id", {12'd0, id}, 16'd0);
        chk("rmid.ie", ie, 16'd0);
        chk("rmid.ip", ip, 16'h0001);
        step();
        reset_n = 1'b1;
`ifdef LCLINT_EDGE_EN
        apply(mk(1, 0, 12'h7C0, 16'h0001, 16'h0001, 16'h0000, 0,
                 16'h0000, 16'h0000, 0, 0, 0), "r2");
        apply(mk(1, 0, 12'h304, 16'h0001, 16'h0001, 16'h0000, 0,
                 16'h0000, 16'h0001, 0, 0, 0), "r3");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0000, 16'h0001, 0, 0, 0), "r4");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0000, 16'h0001, 0, 0, 0), "r5");

        // Edge-mode source 1
        apply(mk(1, 0, 12'h7C0, 16'h0002, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0001, 0, 0, 0), "e1");
        apply(mk(1, 0, 12'h304, 16'h0002, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 0, 0, 0), "e2");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0002, 16'h0000, 0, 16'h0002, 16'h0002, 0, 0, 0), "e3");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e4");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e5");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0002, 0, 1, 0), "e6");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 0, 1, 0), "e7");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0002, 16'h0000, 0, 16'h0002, 16'h0002, 0, 1, 0), "e8");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e9");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0002, 16'h0000, 1, 16'h0002, 16'h0002, 0, 1, 0), "e10");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e11");
        apply(mk(1, 0, 12'h344, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 1, 1, 0), "e12");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 0, 1, 0), "e13");
        apply(mk(1, 0, 12'h344, 16'h0002, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 0, 1, 0), "e14");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e15");
        apply(mk(0, 1, 12'h144, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0002, 1, 1, 0), "e16");
        apply(mk(0, 1, 12'h144, 16'h0000, 16'h0000, 16'h0002, 0, 16'h0000, 16'h0002, 1, 1, 0), "e17");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0000, 16'h0002, 0, 16'h0000, 16'h0002, 0, 1, 0), "e18");
`else
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0001, 16'h0000, 0, 0, 0), "r2");
        apply(mk(1, 0, 12'h304, 16'h0001, 16'h0001, 16'h0000, 0,
                 16'h0001, 16'h0001, 0, 0, 0), "r3");
        apply(mk(0, 0, 12'h000, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0001, 16'h0001, 1, 0, 0), "r4");
        // Writes to MIP/SIP leave a level source alone
        apply(mk(1, 0, 12'h344, 16'h0000, 16'h0001, 16'h0000, 0,
                 16'h0001, 16'h0001, 1, 0, 0), "r5");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
